render_queue_reader: RTL and testbench

Consumer end of the 48-bit render queue. Pops sprite render descriptors from the render FIFO and decodes them. Walks each sprite's pixels in the image memory, which has a synchronous 1-cycle read. Emits a stream of positioned RGB pixels with valid/ready handshake toward the frame compositor, skipping transparent-key pixels.

---
 rtl/render_queue_reader_pkg.sv | 43 ++++
 rtl/render_queue_reader_if.sv | 19 +
 rtl/render_queue_reader_walker.sv | 43 ++++
 rtl/render_queue_reader.sv | 108 ++++++++++
 tb/tb_render_queue_reader.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/render_queue_reader_pkg.sv
// Shared types and constants for the render queue: descriptor layout, sprite slot
// geometry, colour key and the reader FSM encoding.
package render_queue_reader_pkg;

    localparam int DESC_W           = 48;
    localparam int ADDR_W           = 20;
    localparam int RGB_W            = 24;
    localparam int ID_W             = 8;
    localparam int COORD_W          = 10;
    localparam int DIM_W            = 6;
    localparam int SPRITE_SLOT_BITS = 12;

    localparam logic [RGB_W-1:0] KEY_RGB = 24'hFF00FF;

    // Field order matches the 48-bit queue word, MSB first.
    typedef struct packed {
        logic [ID_W-1:0]    sprite_id;
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
        logic [DIM_W-1:0]   wm1;
        logic [DIM_W-1:0]   hm1;
        logic [7:0]         flags;
    } render_desc_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_WAIT = 3'd2,
        ST_EMIT = 3'd3,
        ST_NEXT = 3'd4
    } state_t;

    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [ID_W-1:0]  id,
                                                     input logic [DIM_W-1:0] row,
                                                     input logic [DIM_W-1:0] col);
        return {id, {SPRITE_SLOT_BITS{1'b0}}} | ADDR_W'({row, col});
    endfunction

    function automatic logic is_keyed(input logic key_en, input logic [RGB_W-1:0] rgb);
        return key_en && (rgb == KEY_RGB);
    endfunction

endpackage

// File: rtl/render_queue_reader_if.sv
// Positioned pixel stream from the queue reader to the frame compositor.
interface render_queue_reader_if;
    import render_queue_reader_pkg::*;

    // A pixel transfers on a cycle with pix_valid && pix_ready; once raised,
    // pix_valid and pix_x/pix_y/pix_rgb hold until that cycle, and pix_valid
    // never depends combinationally on pix_ready.
    logic               pix_valid;
    logic               pix_ready;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic [RGB_W-1:0]   pix_rgb;

    modport master (output pix_valid, output pix_x, output pix_y, output pix_rgb,
                    input  pix_ready);
    modport slave  (input  pix_valid, input  pix_x, input  pix_y, input  pix_rgb,
                    output pix_ready);

endinterface

// File: rtl/render_queue_reader_walker.sv
// Row/column walk over one sprite: image address and wrapped screen coordinates.
module render_queue_reader_walker
    import render_queue_reader_pkg::*;
(
    input  logic               clk50,
    input  logic               reset,
    input  logic               start,
    input  logic               step,
    input  logic [ID_W-1:0]    sprite_id,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [DIM_W-1:0]   wm1,
    input  logic [DIM_W-1:0]   hm1,
    output logic [ADDR_W-1:0]  addr,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last
);

    logic [DIM_W-1:0] row;
    logic [DIM_W-1:0] col;

    // step is never issued on the last pixel, so a 64x64 walk stops at 63/63.
    always_ff @(posedge clk50) begin
        if (reset || start) begin
            row <= '0;
            col <= '0;
        end else if (step) begin
            if (col != wm1) begin
                col <= col + 1'b1;
            end else begin
                col <= '0;
                row <= row + 1'b1;
            end
        end
    end

    assign addr = pixel_addr(sprite_id, row, col);
    assign x    = x0 + COORD_W'(col);
    assign y    = y0 + COORD_W'(row);
    assign last = (col == wm1) && (row == hm1);

endmodule

// File: rtl/render_queue_reader.sv
// Consumer of the render queue: pops one sprite descriptor at a time, reads its
// pixels from synchronous image memory and streams the non-keyed ones out.
module render_queue_reader
    import render_queue_reader_pkg::*;
(
    input  logic                  clk50,
    input  logic                  reset,
    input  logic                  q_empty,
    input  logic [DESC_W-1:0]     q_dout,
    output logic                  q_pop_front,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [RGB_W-1:0]      mem_dout,
    render_queue_reader_if.master pix,
    output logic                  busy,
    output state_t                state_dbg
);

    state_t             state;
    state_t             state_nx;
    render_desc_t       desc_r;
    logic [ADDR_W-1:0]  addr_hold;
    logic               valid_r;
    logic [COORD_W-1:0] x_r;
    logic [COORD_W-1:0] y_r;
    logic [RGB_W-1:0]   rgb_r;
    logic               walk_start;
    logic               walk_step;
    logic [ADDR_W-1:0]  walk_addr;
    logic [COORD_W-1:0] walk_x;
    logic [COORD_W-1:0] walk_y;
    logic               walk_last;
    logic               keyed;
    logic               flags_unused;

    assign keyed        = is_keyed(desc_r.flags[0], mem_dout);
    assign flags_unused = ^desc_r.flags[7:1];

    render_queue_reader_walker u_walker (
        .clk50     (clk50),
        .reset     (reset),
        .start     (walk_start),
        .step      (walk_step),
        .sprite_id (desc_r.sprite_id),
        .x0        (desc_r.x0),
        .y0        (desc_r.y0),
        .wm1       (desc_r.wm1),
        .hm1       (desc_r.hm1),
        .addr      (walk_addr),
        .x         (walk_x),
        .y         (walk_y),
        .last      (walk_last)
    );

    always_ff @(posedge clk50) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (!q_empty) state_nx = ST_ADDR;
            ST_ADDR: state_nx = ST_WAIT;
            ST_WAIT: state_nx = keyed ? ST_NEXT : ST_EMIT;
            ST_EMIT: if (pix.pix_ready) state_nx = ST_NEXT;
            ST_NEXT: state_nx = walk_last ? ST_IDLE : ST_ADDR;
            default: state_nx = ST_IDLE;
        endcase
    end

    // The pop is gated by reset so a reset cycle never consumes a descriptor.
    always_comb begin
        q_pop_front = (state == ST_IDLE) && !q_empty && !reset;
        busy        = (state != ST_IDLE);
        walk_start  = q_pop_front;
        walk_step   = (state == ST_NEXT) && !walk_last;
        mem_addr    = (state == ST_ADDR) ? walk_addr : addr_hold;
        state_dbg   = state;
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            desc_r    <= '0;
            addr_hold <= '0;
            valid_r   <= 1'b0;
            x_r       <= '0;
            y_r       <= '0;
            rgb_r     <= '0;
        end else begin
            if (q_pop_front) desc_r <= render_desc_t'(q_dout);
            if (state == ST_ADDR) addr_hold <= walk_addr;
            if (state == ST_WAIT) begin
                rgb_r   <= mem_dout;
                x_r     <= walk_x;
                y_r     <= walk_y;
                valid_r <= !keyed;
            end else if (state == ST_EMIT && pix.pix_ready) begin
                valid_r <= 1'b0;
            end
        end
    end

    assign pix.pix_valid = valid_r;
    assign pix.pix_x     = x_r;
    assign pix.pix_y     = y_r;
    assign pix.pix_rgb   = rgb_r;

endmodule

// File: tb/tb_render_queue_reader.sv
// Bench for render_queue_reader: FIFO and memory models, reference pixel queue
// built from each popped descriptor, randomized backpressure and sprites.
module tb_render_queue_reader;
    import render_queue_reader_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk50 = 1'b0;
    logic reset = 1'b1;
    always #10 clk50 = ~clk50;

    logic              q_empty;
    logic [DESC_W-1:0] q_dout;
    logic              q_pop_front;
    logic [ADDR_W-1:0] mem_addr;
    logic [RGB_W-1:0]  mem_dout;
    logic              busy;
    state_t            state_dbg;

    render_queue_reader_if pix_if ();

    render_queue_reader dut (
        .clk50       (clk50),
        .reset       (reset),
        .q_empty     (q_empty),
        .q_dout      (q_dout),
        .q_pop_front (q_pop_front),
        .mem_addr    (mem_addr),
        .mem_dout    (mem_dout),
        .pix         (pix_if),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    // ---------------- render FIFO model (first-word-fall-through) ----------------
    logic [DESC_W-1:0] desc_arr [0:63];
    int wr_idx = 0;
    int rd_idx = 0;
    assign q_empty = (rd_idx == wr_idx);
    assign q_dout  = desc_arr[rd_idx[5:0]];

    // ---------------- image memory model (1-cycle synchronous read) ----------------
    logic [RGB_W-1:0] mem_ovr [int];

    function automatic logic [RGB_W-1:0] mem_val(input int a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return 24'h100000 | 24'(a);
    endfunction

    always @(posedge clk50) mem_dout <= mem_val(int'(mem_addr));

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    int pop_total  = 0;
    int emit_total = 0;
    int busy_total = 0;
    logic [43:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: every pixel of the sprite in raster order, keyed ones dropped.
    function automatic void expect_sprite(input logic [DESC_W-1:0] word);
        render_desc_t s;
        int a, px, py;
        logic [RGB_W-1:0] rgb;
        s = render_desc_t'(word);
        for (int r = 0; r <= int'(s.hm1); r++) begin
            for (int c = 0; c <= int'(s.wm1); c++) begin
                a   = int'(s.sprite_id) * 4096 + r * 64 + c;
                rgb = mem_val(a);
                if (!(s.flags[0] && rgb == KEY_RGB)) begin
                    px = (int'(s.x0) + c) % 1024;
                    py = (int'(s.y0) + r) % 1024;
                    exp_q.push_back({10'(px), 10'(py), rgb});
                end
            end
        end
    endfunction

    // ---------------- monitor / ready driver (negedge) ----------------
    int          ready_mode = 0;
    int          bp_at      = -1;
    int          stall_run  = 0;
    logic        stall_prev = 1'b0;
    logic        rst_d      = 1'b0;
    logic        rdy;
    logic [43:0] cur;
    logic [43:0] data_prev;
    logic [43:0] exp_pix;

    always @(negedge clk50) begin
        cur = {pix_if.pix_x, pix_if.pix_y, pix_if.pix_rgb};
        if (reset) begin
            if (rst_d) begin
                check("rst_valid", pix_if.pix_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_pop", q_pop_front, 0);
                check("rst_addr", mem_addr, 0);
                check("rst_pix", cur, 0);
            end
            exp_q.delete();
            stall_prev       = 1'b0;
            stall_run        = 0;
            pix_if.pix_ready = 1'b0;
        end else begin
            rdy = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (pix_if.pix_valid && emit_total == bp_at && stall_run < 5) begin
                rdy = 1'b0;
                stall_run++;
            end
            pix_if.pix_ready = rdy;
            if (stall_prev) begin
                check("hold_valid", pix_if.pix_valid, 1);
                check("hold_data", cur, data_prev);
            end
            if (pix_if.pix_valid && rdy) begin
                check("pix_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_pix = exp_q.pop_front();
                    check("pix_xy_rgb", cur, exp_pix);
                end
                emit_total++;
            end
            if (q_pop_front) begin
                check("pop_only_idle", busy, 0);
                check("pop_nonempty", q_empty, 0);
                expect_sprite(q_dout);
                pop_total++;
            end
            if (busy) busy_total++;
            stall_prev = pix_if.pix_valid && !rdy;
            data_prev  = cur;
        end
        rst_d = reset;
    end

    // The pop seen before a rising edge retires the FIFO head just after it.
    always @(posedge clk50) begin
        #1;
        rd_idx = pop_total;
    end

    // ---------------- driver tasks ----------------
    task automatic push_desc(input int id, input int x0, input int y0,
                             input int wm1, input int hm1, input int key_en);
        desc_arr[wr_idx[5:0]] = {8'(id), 10'(x0), 10'(y0), 6'(wm1), 6'(hm1), 7'd0, 1'(key_en)};
        wr_idx++;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk50);
            #3;
            n++;
        end while (!(q_empty && !busy) && n < budget);
        check("done_in_budget", q_empty && !busy, 1);
    endtask

    // ---------------- stimulus ----------------
    int p0, e0, b0, n;

    initial begin
        for (int i = 0; i < 64; i++) desc_arr[i] = '0;
        repeat (4) @(posedge clk50);
        #2 reset = 1'b0;

        // 2x2 sprite with known contents
        mem_ovr[32'h03000] = 24'h000001;
        mem_ovr[32'h03001] = 24'h000002;
        mem_ovr[32'h03040] = 24'h000003;
        mem_ovr[32'h03041] = 24'h000004;
        p0 = pop_total; e0 = emit_total; b0 = busy_total;
        push_desc(3, 100, 50, 1, 1, 0);
        wait_done(200);
        check("t2x2_pops", pop_total - p0, 1);
        check("t2x2_pixels", emit_total - e0, 4);
        check("t2x2_busy_cycles", busy_total - b0, 16);
        check("t2x2_drain", exp_q.size(), 0);

        // 1x3 with key in the middle: keyed and unkeyed
        mem_ovr[32'h05001] = KEY_RGB;
        e0 = emit_total; b0 = busy_total;
        push_desc(5, 200, 10, 2, 0, 1);
        wait_done(200);
        check("key_on_pixels", emit_total - e0, 2);
        check("key_on_busy_cycles", busy_total - b0, 11);
        e0 = emit_total; b0 = busy_total;
        push_desc(5, 200, 10, 2, 0, 0);
        wait_done(200);
        check("key_off_pixels", emit_total - e0, 3);
        check("key_off_busy_cycles", busy_total - b0, 12);

        // backpressure: ready low for 5 cycles while pixel 2 is offered
        e0 = emit_total; b0 = busy_total;
        bp_at = emit_total + 1;
        push_desc(7, 300, 300, 3, 1, 0);
        wait_done(400);
        check("bp_pixels", emit_total - e0, 8);
        check("bp_stall_cycles", stall_run, 5);
        check("bp_busy_cycles", busy_total - b0, 37);
        bp_at = -1;

        // three descriptors back to back
        p0 = pop_total; e0 = emit_total;
        push_desc(8, 10, 10, 1, 0, 0);
        push_desc(9, 20, 20, 0, 1, 0);
        push_desc(10, 30, 30, 2, 2, 0);
        wait_done(400);
        check("q3_pops", pop_total - p0, 3);
        check("q3_pixels", emit_total - e0, 13);
        check("q3_drain", exp_q.size(), 0);

        // empty queue: nothing happens
        p0 = pop_total;
        repeat (20) @(posedge clk50);
        #3;
        check("empty_no_pop", pop_total - p0, 0);
        check("empty_not_busy", busy, 0);

        // coordinate wrap in x and y
        e0 = emit_total;
        push_desc(11, 1020, 1023, 7, 1, 0);
        wait_done(400);
        check("wrap_pixels", emit_total - e0, 16);

        // full 64x64 slot
        e0 = emit_total;
        push_desc(12, 5, 5, 63, 63, 0);
        wait_done(20000);
        check("full_pixels", emit_total - e0, 4096);
        check("full_last_addr", mem_addr, 20'h0CFFF);

        // randomized sprites, keys and backpressure
        ready_mode = 1;
        p0 = pop_total;
        for (int k = 0; k < 6; k++) begin
            int wm1, hm1;
            wm1 = $urandom_range(0, 5);
            hm1 = $urandom_range(0, 5);
            for (int r = 0; r <= hm1; r++)
                for (int c = 0; c <= wm1; c++)
                    if ($urandom_range(0, 3) == 0) mem_ovr[(16 + k) * 4096 + r * 64 + c] = KEY_RGB;
            push_desc(16 + k, $urandom_range(0, 1023), $urandom_range(0, 1023),
                      wm1, hm1, $urandom_range(0, 1));
        end
        wait_done(5000);
        check("rand_pops", pop_total - p0, 6);
        check("rand_drain", exp_q.size(), 0);
        ready_mode = 0;

        // reset in the middle of a sprite, next descriptor waiting
        e0 = emit_total;
        push_desc(20, 0, 0, 3, 3, 0);
        push_desc(21, 40, 40, 1, 1, 0);
        n = 0;
        while (emit_total < e0 + 5 && n < 500) begin
            @(negedge clk50);
            n++;
        end
        check("rst_reach_pixel5", emit_total >= e0 + 5, 1);
        @(posedge clk50);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk50);
        #2 reset = 1'b0;
        p0 = pop_total; e0 = emit_total;
        wait_done(400);
        check("after_rst_pops", pop_total - p0, 1);
        check("after_rst_pixels", emit_total - e0, 4);
        check("after_rst_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
